// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: per-channel 2-flop sync, stability filter,
// registered rise/fall pulses, long-press detection and optional auto-repeat.

module debounce_lane #(
  parameter int STABLE_COUNT = 1000,
  parameter int LONG_COUNT   = 1000000,
  parameter int REPEAT_COUNT = 0,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic repeat_tick
);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam int LW = $clog2(LONG_COUNT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_COUNT - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_COUNT - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_COUNT);

  logic          w_in, w_toggle, w_deb_nxt, w_lp;
  logic          r_s1, r_s2;
  logic [SW-1:0] r_scnt;
  logic [LW-1:0] r_hcnt;

  assign w_in      = (ACTIVE_LOW != 0) ? ~button : button;
  assign w_toggle  = (r_s2 != debounced) && (r_scnt == S_LAST);
  assign w_deb_nxt = debounced ^ w_toggle;
  // Qualified with the next level so a release edge never co-fires with long_press.
  assign w_lp      = debounced && w_deb_nxt && (r_hcnt == L_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_scnt     <= '0;
      r_hcnt     <= '0;
      debounced  <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      r_s1 <= w_in;
      r_s2 <= r_s1;
      if (r_s2 == debounced) begin
        r_scnt <= '0;
      end else if (w_toggle) begin
        debounced <= ~debounced;
        r_scnt    <= '0;
      end else begin
        r_scnt <= r_scnt + 1'b1;
      end
      rise <= w_toggle & ~debounced;
      fall <= w_toggle & debounced;
      if (!debounced)
        r_hcnt <= '0;
      else if (r_hcnt != L_MAX)
        r_hcnt <= r_hcnt + 1'b1;
      long_press <= w_lp;
    end
  end

  generate
    if (REPEAT_COUNT > 0) begin : g_rep
      localparam int RW = $clog2(REPEAT_COUNT + 1);
      localparam logic [RW-1:0] R_LAST = RW'(REPEAT_COUNT - 1);
      logic          r_rep_on;
      logic [RW-1:0] r_rcnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rep_on    <= 1'b0;
          r_rcnt      <= '0;
          repeat_tick <= 1'b0;
        end else begin
          repeat_tick <= 1'b0;
          if (!w_deb_nxt) begin
            r_rep_on <= 1'b0;
            r_rcnt   <= '0;
          end else if (w_lp) begin
            r_rep_on <= 1'b1;
            r_rcnt   <= '0;
          end else if (r_rep_on) begin
            if (r_rcnt == R_LAST) begin
              repeat_tick <= 1'b1;
              r_rcnt      <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
      end
    end else begin : g_norep
      assign repeat_tick = 1'b0;
    end
  endgenerate
endmodule

module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_COUNT = 1000,
  parameter int LONG_COUNT   = 1000000,
  parameter int REPEAT_COUNT = 0,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_tick,
  output logic                any_rise
);
  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_lane
      debounce_lane #(
        .STABLE_COUNT(STABLE_COUNT),
        .LONG_COUNT  (LONG_COUNT),
        .REPEAT_COUNT(REPEAT_COUNT),
        .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_lane (
        .clk        (clk),
        .reset      (reset),
        .button     (button[i]),
        .debounced  (debounced[i]),
        .rise       (rise[i]),
        .fall       (fall[i]),
        .long_press (long_press[i]),
        .repeat_tick(repeat_tick[i])
      );
    end
  endgenerate

  // Built from registered pulses only, so still no path from button.
  assign any_rise = |rise;
endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse output is active.

module tb_debounce_multi;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] button;
  logic [1:0] debounced, rise, fall, long_press, repeat_tick;
  logic       any_rise;
  logic [0:0] button_b, deb_b, rise_b, fall_b, lp_b, tick_b;
  logic       any_b;

  debounce_multi #(.CHANNELS(2), .STABLE_COUNT(4), .LONG_COUNT(10),
                   .REPEAT_COUNT(5), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .reset(reset), .button(button), .debounced(debounced),
    .rise(rise), .fall(fall), .long_press(long_press),
    .repeat_tick(repeat_tick), .any_rise(any_rise));

  debounce_multi #(.CHANNELS(1), .STABLE_COUNT(4), .LONG_COUNT(10),
                   .REPEAT_COUNT(5), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .reset(reset), .button(button_b), .debounced(deb_b),
    .rise(rise_b), .fall(fall_b), .long_press(lp_b),
    .repeat_tick(tick_b), .any_rise(any_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] deb, rise, fall, lp, tick;
    logic       db, rb, fb;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input int c, input logic [1:0] deb, input logic [1:0] ri,
                      input logic [1:0] fa, input logic [1:0] lp, input logic [1:0] tk,
                      input logic db, input logic rb, input logic fb);
    exp_t e;
    e.c = c; e.deb = deb; e.rise = ri; e.fall = fa; e.lp = lp; e.tick = tk;
    e.db = db; e.rb = rb; e.fb = fb;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    logic [16:0] v;
    v = {debounced, rise, fall, long_press, repeat_tick, any_rise,
         deb_b, rise_b, fall_b, lp_b, tick_b, any_b};
    n_vec++;
    if (v != '0) begin
      n_err++;
      $display("FAIL %s @%0d: outputs=%b want all 0", nm, cyc, v);
    end
  endtask

  // Monitor: every active pulse cycle must match the next scoreboard entry.
  exp_t m;
  always @(negedge clk) begin
    if (|{rise, fall, long_press, repeat_tick, any_rise, rise_b, fall_b, lp_b, tick_b, any_b}) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event @%0d: deb=%b rise=%b fall=%b lp=%b tick=%b any=%b b:deb=%b rise=%b fall=%b",
                 cyc, debounced, rise, fall, long_press, repeat_tick, any_rise, deb_b, rise_b, fall_b);
      end else begin
        m = q.pop_front();
        if (cyc != m.c || debounced != m.deb || rise != m.rise || fall != m.fall ||
            long_press != m.lp || repeat_tick != m.tick || any_rise != (|m.rise) ||
            deb_b != m.db || rise_b != m.rb || fall_b != m.fb || lp_b != 1'b0 ||
            tick_b != 1'b0 || any_b != m.rb) begin
          n_err++;
          $display("FAIL event: got cyc=%0d deb=%b rise=%b fall=%b lp=%b tick=%b any=%b b:deb=%b rise=%b fall=%b lp=%b tick=%b; want cyc=%0d deb=%b rise=%b fall=%b lp=%b tick=%b any=%b b:deb=%b rise=%b fall=%b",
                   cyc, debounced, rise, fall, long_press, repeat_tick, any_rise,
                   deb_b, rise_b, fall_b, lp_b, tick_b,
                   m.c, m.deb, m.rise, m.fall, m.lp, m.tick, |m.rise, m.db, m.rb, m.fb);
        end
      end
    end
  end

  int t;
  initial begin
    reset = 1'b1; button = 2'b11; button_b = 1'b1;
    repeat (3) begin
      step(1);
      chk_zero("in_reset");
    end
    reset = 1'b0; button = 2'b00;
    step(4);

    // Clean press and release on ch0.
    t = cyc; button = 2'b01;
    push(t + 6, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(8);
    t = cyc; button = 2'b00;
    push(t + 6, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(10);

    // 3-cycle glitch: filtered out entirely.
    button = 2'b01; step(3); button = 2'b00; step(10);

    // 4-cycle pulse: just long enough to register, then falls 4 cycles later.
    t = cyc; button = 2'b01;
    push(t + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(4); button = 2'b00;
    push(t + 10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(12);

    // Long press with auto-repeat, then release.
    t = cyc; button = 2'b01;
    push(t + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(t + 16, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      push(t + 16 + 5 * k, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    step(29); button = 2'b00;
    push(t + 35, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(12);

    // Reset mid-press on ch1: no fall, fresh rise once reset lifts.
    t = cyc; button = 2'b10;
    push(t + 6, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(10);
    reset = 1'b1; step(1);
    chk_zero("reset_midpress");
    reset = 1'b0;
    push(t + 17, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(8); button = 2'b00;
    push(t + 25, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(10);

    // Simultaneous rise and fall on both channels.
    t = cyc; button = 2'b11;
    push(t + 6,  2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(8); button = 2'b00;
    push(t + 14, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(10);

    // Active-low build: 1->0 on the raw pin is a press.
    t = cyc; button_b = 1'b0;
    push(t + 6,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    step(6); button_b = 1'b1;
    push(t + 12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    step(12);

    while (q.size() > 0) begin
      m = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: absent at cyc=%0d, want cyc=%0d rise=%b fall=%b lp=%b tick=%b b:rise=%b fall=%b",
               cyc, m.c, m.rise, m.fall, m.lp, m.tick, m.rb, m.fb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
